// File: rtl/seg_display_driver_if.sv
// Display-side bundle: binary count and dp mask in, segment/anode drive and conversion status out.
// The slave modport is the driver itself; the master modport is whoever supplies the count.
interface seg_display_driver_if;
  logic [26:0] value;
  logic [3:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] bcd_out;
  logic        busy;
  logic        ovf;

  modport master (
    output value, dp_mask,
    input  seg, dp, an, bcd_out, busy, ovf
  );

  modport slave (
    input  value, dp_mask,
    output seg, dp, an, bcd_out, busy, ovf
  );
endinterface

// File: rtl/seg_display_driver.sv
// Binary-to-BCD (shift-add-3, 16 cycles per sample, 2 on overflow) feeding a multiplexed 4-digit
// common-anode display; free-running, no backpressure: the count is resampled every conversion.
module seg_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  seg_display_driver_if.slave  bus
);

  localparam int            CW   = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_busy;
  logic          w_over;

  logic [13:0]   r_bin;
  logic [15:0]   r_bcd;
  logic [15:0]   w_adj;
  logic [3:0]    r_cnt;
  logic          r_ovf_pend;
  logic [15:0]   r_bcd_out;
  logic          r_ovf;

  logic [CW-1:0] r_rcnt;
  logic [1:0]    r_idx;
  logic [1:0]    r_cur;
  logic          r_lit;
  logic          w_wrap;
  logic [1:0]    w_sel;
  logic [15:0]   w_hi;
  logic          w_blank;
  logic [6:0]    w_glyph;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;

  assign w_over = (bus.value > 27'd9999);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      S_LOAD:   w_next = w_over ? S_COMMIT : S_SHIFT;
      S_SHIFT: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd1) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        w_busy = 1'b1;
        w_next = S_LOAD;
      end
      default:  w_next = S_LOAD;
    endcase
  end

  // Add-3 correction is applied before the shift so each nibble stays a valid BCD digit.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < 4; i++) begin
      w_adj[i*4 +: 4] = (r_bcd[i*4 +: 4] >= 4'd5) ? r_bcd[i*4 +: 4] + 4'd3 : r_bcd[i*4 +: 4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_bcd_out  <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_bin      <= bus.value[13:0];
          r_ovf_pend <= w_over;
          r_bcd      <= '0;
          r_cnt      <= 4'd14;
        end
        S_SHIFT: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt - 4'd1;
        end
        S_COMMIT: begin
          r_ovf <= r_ovf_pend;
          if (!r_ovf_pend) r_bcd_out <= r_bcd;
        end
        default: ;
      endcase
    end
  end

  // On a wrap the segment data must already follow the digit being switched in, so select ahead.
  assign w_wrap  = (r_rcnt == LAST);
  assign w_sel   = w_wrap ? r_idx : r_cur;
  assign w_hi    = r_bcd_out >> {w_sel, 2'b00};
  assign w_blank = BLANK_LZ && (w_sel != 2'd0) && !r_ovf && (w_hi == 16'd0);

  always_comb begin
    w_glyph = 7'h7F;
    if (r_ovf) begin
      w_glyph = 7'b0111111;
    end else if (!w_blank) begin
      case (w_hi[3:0])
        4'd0:    w_glyph = 7'b1000000;
        4'd1:    w_glyph = 7'b1111001;
        4'd2:    w_glyph = 7'b0100100;
        4'd3:    w_glyph = 7'b0110000;
        4'd4:    w_glyph = 7'b0011001;
        4'd5:    w_glyph = 7'b0010010;
        4'd6:    w_glyph = 7'b0000010;
        4'd7:    w_glyph = 7'b1111000;
        4'd8:    w_glyph = 7'b0000000;
        4'd9:    w_glyph = 7'b0010000;
        default: w_glyph = 7'h7F;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rcnt <= '0;
      r_idx  <= '0;
      r_cur  <= '0;
      r_lit  <= 1'b0;
      r_an   <= 4'hF;
      r_seg  <= 7'h7F;
      r_dp   <= 1'b1;
    end else begin
      r_rcnt <= w_wrap ? '0 : r_rcnt + 1'b1;
      if (w_wrap) begin
        r_idx <= r_idx + 2'd1;
        r_cur <= r_idx;
        r_lit <= 1'b1;
        r_an  <= ~(4'b0001 << r_idx);
      end
      r_seg <= (r_lit || w_wrap) ? w_glyph : 7'h7F;
      r_dp  <= (r_lit || w_wrap) ? ~bus.dp_mask[w_sel] : 1'b1;
    end
  end

  assign bus.seg     = r_seg;
  assign bus.dp      = r_dp;
  assign bus.an      = r_an;
  assign bus.bcd_out = r_bcd_out;
  assign bus.busy    = w_busy;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_seg_display_driver.sv
// Bench for seg_display_driver: timeline-level reference model checked every cycle,
// plus directed literal checks and a randomized run with occasional resets.
module tb_seg_display_driver;

  localparam int DIV = 4;
  localparam bit BLZ = 1'b1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  seg_display_driver_if bus();

  seg_display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(BLZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] GLY [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'h7F;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int d);
    case (d)
      0: return 1;
      1: return 10;
      2: return 100;
      default: return 1000;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  // Reference model: edges are numbered from reset release; each conversion is an event
  // scheduled at its sampling edge and retired 15 edges later (1 edge on overflow).
  int         m_n = 0, m_load_at = 1, m_commit_at = -1, m_val = 0, m_pend_val = 0;
  bit         m_ovf = 0, m_pend_ovf = 0, m_busy = 0;
  logic [6:0] m_seg = 7'h7F;
  logic       m_dp  = 1'b1;
  logic [3:0] m_an  = 4'hF;

  initial forever begin
    int d, hi, v;
    @(posedge clk or posedge reset);
    if (reset) begin
      m_n = 0; m_load_at = 1; m_commit_at = -1; m_val = 0; m_pend_val = 0;
      m_ovf = 0; m_pend_ovf = 0; m_busy = 0;
      m_seg = 7'h7F; m_dp = 1'b1; m_an = 4'hF;
    end else begin
      m_n++;
      if (m_n >= DIV) begin
        d    = (m_n / DIV - 1) % 4;
        m_an = ~(4'b0001 << d);
        hi   = m_val / pow10(d);
        if (m_ovf)                        m_seg = DASH;
        else if (BLZ && d > 0 && hi == 0) m_seg = BLANK;
        else                              m_seg = GLY[hi % 10];
        m_dp = ~bus.dp_mask[d];
      end
      if (m_n == m_load_at) begin
        v = int'(bus.value);
        m_pend_ovf  = (v > 9999);
        m_pend_val  = v;
        m_commit_at = m_n + (m_pend_ovf ? 1 : 15);
        m_busy      = 1;
      end else if (m_n == m_commit_at) begin
        if (!m_pend_ovf) m_val = m_pend_val;
        m_ovf     = m_pend_ovf;
        m_busy    = 0;
        m_load_at = m_n + 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("seg",     32'(bus.seg),     32'(m_seg));
    chk("dp",      32'(bus.dp),      32'(m_dp));
    chk("an",      32'(bus.an),      32'(m_an));
    chk("bcd_out", 32'(bus.bcd_out), 32'(to_bcd(m_val)));
    chk("busy",    32'(bus.busy),    32'(m_busy));
    chk("ovf",     32'(bus.ovf),     32'(m_ovf));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic scan(input string nm, input logic [6:0] e0, input logic [6:0] e1,
                      input logic [6:0] e2, input logic [6:0] e3);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (bus.an)
        4'b1110: chk({nm, "_d0"}, 32'(bus.seg), 32'(e0));
        4'b1101: chk({nm, "_d1"}, 32'(bus.seg), 32'(e1));
        4'b1011: chk({nm, "_d2"}, 32'(bus.seg), 32'(e2));
        4'b0111: chk({nm, "_d3"}, 32'(bus.seg), 32'(e3));
        default: ;
      endcase
    end
  endtask

  initial begin
    int k;
    bus.value   = 27'd1234;
    bus.dp_mask = 4'b0000;
    step(2);
    reset = 1'b0;

    // Anode stepping and first conversion latency
    step(3);
    chk("an_before_wrap", 32'(bus.an), 32'h0000000F);
    step(1);
    chk("an_first", 32'(bus.an), 32'h0000000E);
    step(4);
    chk("an_second", 32'(bus.an), 32'h0000000D);
    step(4);
    chk("an_third", 32'(bus.an), 32'h0000000B);
    step(3);
    chk("bcd_edge15", 32'(bus.bcd_out), 32'h00000000);
    chk("busy_edge15", 32'(bus.busy), 32'h00000001);
    step(1);
    chk("bcd_1234", 32'(bus.bcd_out), 32'h00001234);
    chk("ovf_1234", 32'(bus.ovf), 32'h00000000);
    chk("an_fourth", 32'(bus.an), 32'h00000007);
    bus.value = 27'd10000;
    step(1);
    chk("seg_d3_1234", 32'(bus.seg), 32'h00000079);
    chk("ovf_pending", 32'(bus.ovf), 32'h00000000);
    step(1);
    chk("ovf_set", 32'(bus.ovf), 32'h00000001);
    chk("bcd_kept", 32'(bus.bcd_out), 32'h00001234);
    scan("dash", DASH, DASH, DASH, DASH);

    // Leading-zero blanking
    bus.value = 27'd42;
    step(40);
    scan("v42", 7'b0100100, 7'b0011001, BLANK, BLANK);
    bus.value = 27'd0;
    step(40);
    scan("v0", 7'b1000000, BLANK, BLANK, BLANK);

    // Sample held across a busy-time change of value
    bus.value = 27'd1234;
    do_reset();
    step(5);
    chk("busy_mid", 32'(bus.busy), 32'h00000001);
    bus.value = 27'd5678;
    step(11);
    chk("commit_old", 32'(bus.bcd_out), 32'h00001234);
    step(15);
    chk("hold_old", 32'(bus.bcd_out), 32'h00001234);
    step(1);
    chk("commit_new", 32'(bus.bcd_out), 32'h00005678);

    // Reset in the middle of SHIFT
    bus.dp_mask = 4'b0100;
    bus.value   = 27'd1234;
    k = 0;
    while (bus.busy !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("busy_wait", 32'(bus.busy), 32'h00000001);
    step(2);
    reset = 1'b1;
    #1;
    chk("rst_seg", 32'(bus.seg), 32'h0000007F);
    chk("rst_dp", 32'(bus.dp), 32'h00000001);
    chk("rst_an", 32'(bus.an), 32'h0000000F);
    chk("rst_bcd", 32'(bus.bcd_out), 32'h00000000);
    chk("rst_busy", 32'(bus.busy), 32'h00000000);
    chk("rst_ovf", 32'(bus.ovf), 32'h00000000);
    step(2);
    reset = 1'b0;
    step(15);
    chk("post_rst_bcd15", 32'(bus.bcd_out), 32'h00000000);
    step(1);
    chk("post_rst_bcd16", 32'(bus.bcd_out), 32'h00001234);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.an != 4'hF)
        chk("dp_mask_digit2", 32'(bus.dp), (bus.an == 4'b1011) ? 32'h0 : 32'h1);
    end

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0: bus.value = 27'($urandom_range(0, 9));
          1: bus.value = 27'($urandom_range(0, 999));
          2: bus.value = 27'($urandom_range(0, 9999));
          3: bus.value = 27'd9999;
          4: bus.value = 27'd10000;
          default: bus.value = 27'($urandom);
        endcase
      end
      if ($urandom_range(0, 9) == 0) bus.dp_mask = 4'($urandom);
    end
    reset = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
